// File: rtl/arty_input_conditioner.sv
// -----------------------------------------------------------------------------
// arty_input_conditioner
//
// Conditions the Arty push-buttons and slide switches before they reach the
// SoC GPIO inputs. Each input bit is handled independently:
//   raw pin -> 2-flop synchroniser -> counter debounce -> rise/fall pulses
//   -> sticky event flag.
// The event flags are masked per bit and OR-reduced into one registered
// level interrupt.
//
// Ports
//   clk          system clock (100 MHz)
//   rst_n        asynchronous assert, active-low reset
//   in_raw_i     raw asynchronous pin levels
//                (btn[3:0] on bits 3:0, sw[3:0] on bits 7:4)
//   level_o      debounced stable level
//   rise_o       one-cycle pulse on each accepted 0->1 transition
//   fall_o       one-cycle pulse on each accepted 1->0 transition
//   event_o      sticky flag, set by any accepted edge
//   event_clr_i  per-bit clear strobe for event_o
//   irq_en_i     per-bit interrupt enable
//   irq_o        registered OR of (event_o & irq_en_i)
// -----------------------------------------------------------------------------
module arty_input_conditioner #(
    parameter int   NUM_IN          = 8,
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1),
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] in_raw_i,
    output logic [NUM_IN-1:0] level_o,
    output logic [NUM_IN-1:0] rise_o,
    output logic [NUM_IN-1:0] fall_o,
    output logic [NUM_IN-1:0] event_o,
    input  logic [NUM_IN-1:0] event_clr_i,
    input  logic [NUM_IN-1:0] irq_en_i,
    output logic              irq_o
);

    // Counter value at which a differing level has been stable long enough.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0]    sync_meta;
    logic [NUM_IN-1:0]    sync_q;
    logic [NUM_IN-1:0]    level_q;
    logic [NUM_IN-1:0]    rise_q;
    logic [NUM_IN-1:0]    fall_q;
    logic [NUM_IN-1:0]    event_q;
    logic                 irq_q;
    logic [CNT_WIDTH-1:0] cnt [NUM_IN];

    // Two-flop synchroniser; sync_q lags in_raw_i by two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= {NUM_IN{RESET_LEVEL}};
            sync_q    <= {NUM_IN{RESET_LEVEL}};
        end else begin
            sync_meta <= in_raw_i;
            sync_q    <= sync_meta;
        end
    end

    // Debounce: count consecutive cycles where the synchronised input differs
    // from the accepted level. Any agreement restarts the count, so only a
    // difference held for DEBOUNCE_CYCLES edges is accepted. The edge pulses
    // are registered on the same edge as the level so they line up with the
    // first cycle that shows the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= {NUM_IN{RESET_LEVEL}};
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                if (sync_q[i] == level_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level_q[i] <= sync_q[i];
                    rise_q[i]  <= sync_q[i];
                    fall_q[i]  <= ~sync_q[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sticky events: a new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q <= '0;
        end else begin
            event_q <= (event_q & ~event_clr_i) | rise_q | fall_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(event_q & irq_en_i);
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = event_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_arty_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_arty_input_conditioner
//
// Directed bench for arty_input_conditioner with DEBOUNCE_CYCLES = 4, so a
// held raw change shows on level_o six edges after it is first sampled.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_arty_input_conditioner;

    localparam int NUM_IN = 8;
    localparam int DEB    = 4;

    logic              clk;
    logic              rst_n;
    logic [NUM_IN-1:0] in_raw_i;
    logic [NUM_IN-1:0] level_o;
    logic [NUM_IN-1:0] rise_o;
    logic [NUM_IN-1:0] fall_o;
    logic [NUM_IN-1:0] event_o;
    logic [NUM_IN-1:0] event_clr_i;
    logic [NUM_IN-1:0] irq_en_i;
    logic              irq_o;

    int vectors     = 0;
    int miscompares = 0;

    arty_input_conditioner #(
        .NUM_IN          (NUM_IN),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_raw_i    (in_raw_i),
        .level_o     (level_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .event_o     (event_o),
        .event_clr_i (event_clr_i),
        .irq_en_i    (irq_en_i),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_raw_i    = '0;
        event_clr_i = '0;
        irq_en_i    = '0;

        // Reset
        tick(10);
        chk("rst_level", level_o, 8'h00);
        chk("rst_rise",  rise_o,  8'h00);
        chk("rst_fall",  fall_o,  8'h00);
        chk("rst_event", event_o, 8'h00);
        chk("rst_irq",   irq_o,   1'b0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_rise", rise_o, 8'h00);

        // Stable rise on bit 0
        in_raw_i = 8'h01;
        tick(5);
        chk("t1_level_e5", level_o, 8'h00);
        tick(1);
        chk("t1_level_e6", level_o, 8'h01);
        chk("t1_rise_e6",  rise_o,  8'h01);
        chk("t1_event_e6", event_o, 8'h00);
        tick(1);
        chk("t1_rise_e7",  rise_o,  8'h00);
        chk("t1_event_e7", event_o, 8'h01);
        chk("t1_irq_e7",   irq_o,   1'b0);
        tick(1);
        chk("t1_irq_e8",   irq_o,   1'b0);

        // Glitch of 3 cycles on bit 2 is rejected
        in_raw_i = 8'h05;
        tick(3);
        in_raw_i = 8'h01;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk("t2_rise", rise_o,  8'h00);
            chk("t2_level", level_o, 8'h01);
        end
        chk("t2_event", event_o, 8'h01);
        chk("t2_cnt2",  dut.cnt[2], 0);

        // Accept bit 2 so event_o = 8'h05
        in_raw_i = 8'h05;
        tick(6);
        chk("t4_level", level_o, 8'h05);
        chk("t4_rise",  rise_o,  8'h04);
        tick(1);
        chk("t4_event", event_o, 8'h05);
        irq_en_i = 8'h02;
        tick(1);
        chk("t4_irq_masked", irq_o, 1'b0);
        irq_en_i = 8'h04;
        tick(1);
        chk("t4_irq_enabled", irq_o, 1'b1);
        irq_en_i = 8'h00;
        tick(1);
        chk("t4_irq_disabled", irq_o, 1'b0);
        chk("t4_event_kept",   event_o, 8'h05);
        irq_en_i = 8'h04;
        tick(1);
        chk("t4_irq_reen", irq_o, 1'b1);
        event_clr_i = 8'h04;
        tick(1);
        event_clr_i = 8'h00;
        chk("t4_event_clr", event_o, 8'h01);
        chk("t4_irq_lag",   irq_o,   1'b1);
        tick(1);
        chk("t4_irq_drop",  irq_o,   1'b0);
        irq_en_i = 8'h00;

        // Set/clear collision on bit 1
        in_raw_i = 8'h07;
        tick(6);
        chk("t3_rise1", rise_o, 8'h02);
        tick(1);
        chk("t3_event_pend", event_o, 8'h03);
        in_raw_i = 8'h05;
        tick(5);
        chk("t3_fall_e5", fall_o, 8'h00);
        tick(1);
        chk("t3_fall_e6",  fall_o,  8'h02);
        chk("t3_rise_e6",  rise_o,  8'h00);
        chk("t3_level_e6", level_o, 8'h05);
        event_clr_i = 8'h02;
        tick(1);
        event_clr_i = 8'h00;
        chk("t3_set_wins", event_o, 8'h03);
        chk("t3_fall_one", fall_o,  8'h00);
        event_clr_i = 8'h02;
        tick(1);
        event_clr_i = 8'h00;
        chk("t3_clr_alone", event_o, 8'h01);
        event_clr_i = 8'h02;
        tick(1);
        event_clr_i = 8'h00;
        chk("t3_clr_again", event_o, 8'h01);

        // Independence: sw[3:0] -> 4'b1010
        in_raw_i = 8'hA5;
        tick(6);
        chk("t5_level", level_o, 8'hA5);
        chk("t5_rise",  rise_o,  8'hA0);
        chk("t5_fall",  fall_o,  8'h00);
        tick(1);
        chk("t5_rise_off", rise_o,  8'h00);
        chk("t5_event",    event_o, 8'hA1);

        // Reset in the middle of a count on bit 3
        event_clr_i = 8'hFF;
        tick(1);
        event_clr_i = 8'h00;
        chk("t6_event_cleared", event_o, 8'h00);
        in_raw_i = 8'hAD;
        tick(4);
        chk("t6_cnt3", dut.cnt[3], 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", level_o, 8'h00);
        chk("t6_rst_event", event_o, 8'h00);
        chk("t6_rst_irq",   irq_o,   1'b0);
        chk("t6_rst_cnt3",  dut.cnt[3], 0);
        tick(5);
        chk("t6_rst_rise", rise_o, 8'h00);
        chk("t6_rst_fall", fall_o, 8'h00);
        rst_n = 1'b1;
        tick(5);
        chk("t6_level_e5", level_o, 8'h00);
        tick(1);
        chk("t6_level_e6", level_o, 8'hAD);
        chk("t6_rise_e6",  rise_o,  8'hAD);
        tick(1);
        chk("t6_rise_e7",  rise_o,  8'h00);
        chk("t6_event_e7", event_o, 8'hAD);
        chk("t6_irq_e7",   irq_o,   1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arty_input_conditioner.md
Name: arty_input_conditioner

Overview:
Conditions the Arty board's asynchronous push-buttons and slide switches before they reach the PULPino SoC GPIO inputs. It sits inside the board top, between the btn/sw pins and the SoC. Per input it performs 2-flop synchronisation, counter-based debounce, single-cycle rise/fall pulse generation and sticky event capture. It also provides a maskable level interrupt line to the SoC.

Parameters:
NUM_IN, 8, number of conditioned inputs (btn[3:0] on bits 3:0, sw[3:0] on bits 7:4)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a new level (10 ms at 100 MHz); must be >= 1
CNT_WIDTH, $clog2(DEBOUNCE_CYCLES+1), debounce counter width
RESET_LEVEL, 1'b0, reset value of the synchroniser flops and debounced levels (applies to all bits)

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  reset; asynchronous assert, active-low
in_raw_i  input  NUM_IN  raw asynchronous pin levels
level_o  output  NUM_IN  debounced stable level
rise_o  output  NUM_IN  one-cycle pulse on each accepted 0->1 transition
fall_o  output  NUM_IN  one-cycle pulse on each accepted 1->0 transition
event_o  output  NUM_IN  sticky flag, set by any accepted edge
event_clr_i  input  NUM_IN  per-bit clear of event_o, one-cycle strobe
irq_en_i  input  NUM_IN  per-bit interrupt enable
irq_o  output  1  registered OR of (event_o & irq_en_i)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values, all bits:
  - sync flops = RESET_LEVEL; level_o = RESET_LEVEL.
  - rise_o = 0; fall_o = 0; event_o = 0; irq_o = 0.
  - All counters = 0.
- Bits are fully independent. Only the event-to-irq OR reduction combines them.
- Synchroniser: two flops per bit. sync = second flop, so sync follows in_raw_i with 2-cycle delay.
- Debounce, per bit, evaluated at each clk edge:
  - sync == level: cnt <= 0.
  - sync != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync != level and cnt == DEBOUNCE_CYCLES-1: level <= sync and cnt <= 0.
- Latency: a raw change held stable changes level_o exactly DEBOUNCE_CYCLES+2 clk edges after the first edge that samples it.
- Glitch rejection: any return of sync to level before acceptance resets cnt. A pulse shorter than DEBOUNCE_CYCLES cycles (after sync) never changes level_o.
- Pulses:
  - rise_o/fall_o are registered at the same edge that updates level.
  - They are high for exactly the one cycle in which level_o first shows the new value.
  - They never assert together on one bit. They never assert after reset without a real transition.
- Events:
  - event_o[i] <= (event_o[i] & ~event_clr_i[i]) | rise[i] | fall[i].
  - If a set and a clear land in the same cycle, the set wins and the bit stays 1.
  - Clearing an already-clear bit has no effect.
- Interrupt:
  - irq_o <= |(event_o & irq_en_i), registered, so it lags event_o by 1 cycle.
  - Enabling a bit whose event is already pending raises irq_o on the next edge.
  - Deasserting irq_en_i drops irq_o next edge without touching event_o.
- Reset mid-count: rst_n low immediately clears all state. After release, counting restarts from 0 against RESET_LEVEL. No edge pulse is generated for a pin already at RESET_LEVEL.
- DEBOUNCE_CYCLES=1: level follows sync with 1 cycle of delay; no filtering.

Test Plan:
- Stable rise (sim DEBOUNCE_CYCLES=4): rst_n low 10 cycles, then release; in_raw_i[0] 0->1 and held. -> level_o[0]=1 at edge 6 after the change; rise_o[0]=1 for that cycle only; event_o[0]=1 next cycle; irq_o stays 0 while irq_en_i=0.
- Glitch reject: in_raw_i[2] high for 3 cycles, then low. -> level_o, rise_o and event_o all stay 0; internal cnt returns to 0.
- Clear vs set collision: event_o[1]=1 pending; assert event_clr_i[1] in the same cycle as a new fall_o[1]. -> event_o[1] remains 1. A later clear alone -> 0.
- Interrupt masking: event_o=8'h05, irq_en_i=8'h02 -> irq_o=0. Set irq_en_i=8'h04 -> irq_o=1 one edge later. Clear bit 2 -> irq_o=0 one edge after the clear.
- Independence: toggle in_raw_i[7:4] to 4'b1010 simultaneously and hold. -> level_o[7:4]=4'b1010; rise_o[7] and rise_o[5] pulse in the same cycle; bits 6 and 4 show no pulse.
- Reset mid-count: assert rst_n low when cnt=2 with in_raw_i[3]=1, release after 5 cycles. -> all outputs 0 during reset; level_o[3]=1 exactly 6 edges after release, with one rise_o[3] pulse.
